// File: rtl/mem_req_queue_if.sv
// mem_req_queue_if
//   Bundles the pipeline push port, the mem_system issue/return signals, the
//   response strobe and the status flags of mem_req_queue.
//   slave  : the queue itself (drives in_ready, mem_*, rsp_*, status)
//   master : the pipeline / memory side (drives in_*, mem_dataout/done/stall/hit)
//   Optional macro MEM_REQ_STATS_EN adds stat_reqs, stat_hits, stat_maxlat.
interface mem_req_queue_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_wr;
    logic [15:0] in_addr;
    logic [15:0] in_data;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_datain;
    logic [15:0] mem_dataout;
    logic        mem_done;
    logic        mem_stall;
    logic        mem_hit;
    logic        rsp_valid;
    logic        rsp_wr;
    logic [15:0] rsp_data;
    logic        rsp_hit;
    logic        empty;
    logic        full;
    logic        timeout;
`ifdef MEM_REQ_STATS_EN
    logic [15:0] stat_reqs;
    logic [15:0] stat_hits;
    logic [4:0]  stat_maxlat;
`endif

    modport slave (
        input  in_valid, in_wr, in_addr, in_data,
               mem_dataout, mem_done, mem_stall, mem_hit,
        output in_ready, mem_rd, mem_wr, mem_addr, mem_datain,
               rsp_valid, rsp_wr, rsp_data, rsp_hit, empty, full, timeout
`ifdef MEM_REQ_STATS_EN
               , stat_reqs, stat_hits, stat_maxlat
`endif
    );

    modport master (
        output in_valid, in_wr, in_addr, in_data,
               mem_dataout, mem_done, mem_stall, mem_hit,
        input  in_ready, mem_rd, mem_wr, mem_addr, mem_datain,
               rsp_valid, rsp_wr, rsp_data, rsp_hit, empty, full, timeout
`ifdef MEM_REQ_STATS_EN
               , stat_reqs, stat_hits, stat_maxlat
`endif
    );
endinterface

// File: rtl/mem_req_queue.sv
// mem_req_queue
//   Request FIFO and single-outstanding issuer in front of mem_system.
//   Ports:
//     clk  - system clock
//     rst  - synchronous reset, active-low
//     bus  - mem_req_queue_if.slave: push port (in_*), mem_system side
//            (mem_*), one-cycle response strobe (rsp_*), status
//            (empty, full, timeout)
//   Parameters: DEPTH (FIFO entries, power of two >= 2), LAT_LIMIT (cycles
//   from issue to Done before timeout sets).
//   Optional macro MEM_REQ_STATS_EN adds completion/hit counters and the
//   maximum observed latency.
module mem_req_queue #(
    parameter int DEPTH     = 4,
    parameter int LAT_LIMIT = 20
) (
    input  logic           clk,
    input  logic           rst,
    mem_req_queue_if.slave bus
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [31:0] LIMIT_U  = 32'(LAT_LIMIT);

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state_q, state_d;

    // Entry layout: {wr, addr[15:0], data[15:0]}
    logic [32:0]   fifo_q [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          full, empty;
    logic          push, pop, rsp_load, go_idle;
    logic [32:0]   head;

    logic          iss_rd, iss_wr;
    logic [15:0]   iss_addr, iss_data;
    logic          rsp_valid_q, rsp_wr_q, rsp_hit_q;
    logic [15:0]   rsp_data_q;
    logic          timeout_q;
    logic [4:0]    lat_q, lat_inc;
    logic          unused_stall;

    // Stall only explains why Done is late; it never gates completion.
    assign unused_stall = bus.mem_stall;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign push  = bus.in_valid && !full;
    assign head  = fifo_q[rd_ptr];

    // Latency of the current BUSY cycle counting from 1, saturating at 31.
    assign lat_inc = (lat_q == '1) ? lat_q : lat_q + 5'd1;

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        rsp_load = 1'b0;
        go_idle  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus.mem_done) begin
                    rsp_load = 1'b1;
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        go_idle = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr] <= {bus.in_wr, bus.in_addr, bus.in_data};
                wr_ptr         <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (pop && !push) count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            iss_rd      <= 1'b0;
            iss_wr      <= 1'b0;
            iss_addr    <= '0;
            iss_data    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_wr_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_hit_q   <= 1'b0;
            timeout_q   <= 1'b0;
            lat_q       <= '0;
        end else begin
            rsp_valid_q <= rsp_load;
            if (rsp_load) begin
                rsp_wr_q   <= iss_wr;
                rsp_data_q <= iss_wr ? '0 : bus.mem_dataout;
                rsp_hit_q  <= bus.mem_hit;
            end
            if (pop) begin
                iss_wr   <= head[32];
                iss_rd   <= !head[32];
                iss_addr <= head[31:16];
                iss_data <= head[15:0];
                lat_q    <= '0;
            end else begin
                if (state_q == BUSY) lat_q <= lat_inc;
                if (go_idle) begin
                    iss_rd <= 1'b0;
                    iss_wr <= 1'b0;
                end
            end
            // Sets once a request has been outstanding more than LAT_LIMIT
            // BUSY cycles without Done.
            if (state_q == BUSY && !bus.mem_done && {27'd0, lat_inc} > LIMIT_U)
                timeout_q <= 1'b1;
        end
    end

    assign bus.in_ready   = !full;
    assign bus.empty      = empty;
    assign bus.full       = full;
    assign bus.mem_rd     = iss_rd;
    assign bus.mem_wr     = iss_wr;
    assign bus.mem_addr   = iss_addr;
    assign bus.mem_datain = iss_data;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_wr     = rsp_wr_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_hit    = rsp_hit_q;
    assign bus.timeout    = timeout_q;

`ifdef MEM_REQ_STATS_EN
    logic [15:0] reqs_q, hits_q;
    logic [4:0]  maxlat_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            reqs_q   <= '0;
            hits_q   <= '0;
            maxlat_q <= '0;
        end else if (rsp_load) begin
            if (reqs_q != '1)                 reqs_q   <= reqs_q + 16'd1;
            if (bus.mem_hit && hits_q != '1)  hits_q   <= hits_q + 16'd1;
            if (lat_inc > maxlat_q)           maxlat_q <= lat_inc;
        end
    end

    assign bus.stat_reqs   = reqs_q;
    assign bus.stat_hits   = hits_q;
    assign bus.stat_maxlat = maxlat_q;
`endif
endmodule

// File: tb/tb_mem_req_queue.sv
// tb_mem_req_queue
//   Directed scenarios plus randomized traffic for mem_req_queue, checked
//   every cycle against a queue-based reference model of the request flow.
module tb_mem_req_queue;
    localparam int DEPTH     = 4;
    localparam int LAT_LIMIT = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_req_queue_if bus_if();

    mem_req_queue #(.DEPTH(DEPTH), .LAT_LIMIT(LAT_LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
    } req_t;

    // Reference model state
    req_t        q[$];
    req_t        cur;
    bit          cur_v;
    int          busy_n;
    logic [15:0] e_addr, e_datain, e_rspdata;
    logic        e_rspv, e_rspwr, e_rsphit, e_timeout;
    int          e_reqs, e_hits, e_maxlat;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic v, input logic w,
                              input logic [15:0] a, input logic [15:0] d,
                              input logic dn, input logic [15:0] dout, input logic h);
        int sz, k;
        req_t nr;
        if (!r) begin
            q.delete();
            cur_v = 0; busy_n = 0;
            e_addr = '0; e_datain = '0;
            e_rspv = 0; e_rspwr = 0; e_rspdata = '0; e_rsphit = 0;
            e_timeout = 0; e_reqs = 0; e_hits = 0; e_maxlat = 0;
            return;
        end
        sz = q.size();
        e_rspv = 0;
        if (cur_v) begin
            k = (busy_n + 1 > 31) ? 31 : busy_n + 1;
            if (dn) begin
                e_rspv    = 1;
                e_rspwr   = cur.wr;
                e_rspdata = cur.wr ? 16'h0 : dout;
                e_rsphit  = h;
                if (e_reqs < 65535) e_reqs++;
                if (h && e_hits < 65535) e_hits++;
                if (k > e_maxlat) e_maxlat = k;
                cur_v = 0;
            end else begin
                if (k > LAT_LIMIT) e_timeout = 1;
                busy_n = k;
            end
        end
        if (!cur_v && sz > 0) begin
            cur      = q.pop_front();
            cur_v    = 1;
            busy_n   = 0;
            e_addr   = cur.addr;
            e_datain = cur.data;
        end
        if (v && sz < DEPTH) begin
            nr.wr = w; nr.addr = a; nr.data = d;
            q.push_back(nr);
        end
    endtask

    task automatic check_all();
        check_eq("mem_rd",     32'(bus_if.mem_rd),     32'(cur_v && !cur.wr));
        check_eq("mem_wr",     32'(bus_if.mem_wr),     32'(cur_v && cur.wr));
        check_eq("mem_addr",   32'(bus_if.mem_addr),   32'(e_addr));
        check_eq("mem_datain", 32'(bus_if.mem_datain), 32'(e_datain));
        check_eq("rsp_valid",  32'(bus_if.rsp_valid),  32'(e_rspv));
        check_eq("rsp_wr",     32'(bus_if.rsp_wr),     32'(e_rspwr));
        check_eq("rsp_data",   32'(bus_if.rsp_data),   32'(e_rspdata));
        check_eq("rsp_hit",    32'(bus_if.rsp_hit),    32'(e_rsphit));
        check_eq("empty",      32'(bus_if.empty),      32'(q.size() == 0));
        check_eq("full",       32'(bus_if.full),       32'(q.size() == DEPTH));
        check_eq("in_ready",   32'(bus_if.in_ready),   32'(q.size() != DEPTH));
        check_eq("timeout",    32'(bus_if.timeout),    32'(e_timeout));
`ifdef MEM_REQ_STATS_EN
        check_eq("stat_reqs",   32'(bus_if.stat_reqs),   32'(e_reqs));
        check_eq("stat_hits",   32'(bus_if.stat_hits),   32'(e_hits));
        check_eq("stat_maxlat", 32'(bus_if.stat_maxlat), 32'(e_maxlat));
`endif
    endtask

    // One clock: check state left by the previous edge, drive, clock the model.
    task automatic cycle(input logic r, input logic v, input logic w,
                         input logic [15:0] a, input logic [15:0] d,
                         input logic dn, input logic [15:0] dout, input logic h);
        @(negedge clk);
        check_all();
        rst                = r;
        bus_if.in_valid    = v;
        bus_if.in_wr       = w;
        bus_if.in_addr     = a;
        bus_if.in_data     = d;
        bus_if.mem_done    = dn;
        bus_if.mem_dataout = dout;
        bus_if.mem_hit     = h;
        bus_if.mem_stall   = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        model_edge(r, v, w, a, d, dn, dout, h);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, '0, '0, 0, '0, 0);
    endtask

    task automatic do_reset();
        cycle(0, 0, 0, '0, '0, 0, '0, 0);
        cycle(1, 0, 0, '0, '0, 0, '0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (!cur_v && q.size() == 0) return;
            cycle(1, 0, 0, '0, '0, logic'(cur_v), 16'h5A5A, 0);
        end
        check_eq("drain_bound", 32'(cur_v || q.size() != 0), 32'd0);
    endtask

    // Push one request into an idle queue and complete it after lat BUSY cycles.
    task automatic run_req(input logic w, input logic [15:0] a, input logic [15:0] d,
                           input int lat, input logic h, input logic [15:0] dout);
        cycle(1, 1, w, a, d, 0, '0, 0);
        cycle(1, 0, 0, '0, '0, 0, '0, 0);
        for (int i = 1; i < lat; i++) cycle(1, 0, 0, '0, '0, 0, '0, 0);
        cycle(1, 0, 0, '0, '0, 1, dout, h);
    endtask

    initial begin
        int pv, pd;
        logic r, v, dn;
        bus_if.in_valid = 0; bus_if.in_wr = 0; bus_if.in_addr = '0; bus_if.in_data = '0;
        bus_if.mem_done = 0; bus_if.mem_dataout = '0; bus_if.mem_hit = 0; bus_if.mem_stall = 0;
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        model_edge(0, 0, 0, '0, '0, 0, '0, 0);
        idle(1);

        // Single read, miss, data 0xBEEF
        cycle(1, 1, 0, 16'h0010, 16'h0, 0, '0, 0);
        cycle(1, 0, 0, '0, '0, 0, '0, 0);
        check_eq("rd_issue_mem_rd", 32'(bus_if.mem_rd), 32'd1);
        check_eq("rd_issue_addr", 32'(bus_if.mem_addr), 32'h0010);
        idle(3);
        cycle(1, 0, 0, '0, '0, 1, 16'hBEEF, 0);
        check_eq("rd_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
        check_eq("rd_rsp_data", 32'(bus_if.rsp_data), 32'hBEEF);
        check_eq("rd_rsp_mem_rd", 32'(bus_if.mem_rd), 32'd0);
        idle(2);

        // Fill with writes while memory stalls, then drain back-to-back
        for (int i = 0; i < 6; i++)
            cycle(1, 1, 1, 16'h0100 + 16'(2 * i), 16'(i + 1), 0, '0, 0);
        check_eq("fill_full", 32'(bus_if.full), 32'd1);
        check_eq("fill_in_ready", 32'(bus_if.in_ready), 32'd0);
        for (int i = 0; i < 3; i++) cycle(1, 1, 1, 16'h0200, 16'h0009, 0, '0, 0);
        for (int i = 0; i < 12; i++) cycle(1, 0, 0, '0, '0, logic'(cur_v), '0, 0);
        drain();
        idle(1);

        // Hit on first BUSY cycle
        run_req(0, 16'h0042, 16'h0, 1, 1, 16'h1111);
        check_eq("hit_rsp_hit", 32'(bus_if.rsp_hit), 32'd1);
        idle(2);

        // Long miss, timeout sticky across a later normal request
        run_req(0, 16'h0300, 16'h0, 26, 0, 16'h2222);
        check_eq("to_set", 32'(bus_if.timeout), 32'd1);
        idle(1);
        run_req(1, 16'h0302, 16'h7777, 3, 1, 16'h0);
        idle(1);
        check_eq("to_sticky", 32'(bus_if.timeout), 32'd1);

        // Reset while BUSY with 2 entries queued
        do_reset();
        cycle(1, 1, 0, 16'h0400, 16'h0, 0, '0, 0);
        cycle(1, 1, 1, 16'h0402, 16'hAAAA, 0, '0, 0);
        cycle(1, 1, 0, 16'h0404, 16'h0, 0, '0, 0);
        cycle(0, 0, 0, '0, '0, 1, 16'hDEAD, 1);
        check_eq("rst_mem_rd", 32'(bus_if.mem_rd), 32'd0);
        check_eq("rst_mem_wr", 32'(bus_if.mem_wr), 32'd0);
        check_eq("rst_empty", 32'(bus_if.empty), 32'd1);
        check_eq("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, '0, '0, 1, 16'hDEAD, 1);

        // Stats scenario: hit/1, miss/12, hit/1
        do_reset();
        run_req(0, 16'h0500, 16'h0, 1, 1, 16'h0001);
        run_req(1, 16'h0502, 16'h0002, 12, 0, 16'h0);
        run_req(0, 16'h0504, 16'h0, 1, 1, 16'h0003);
        idle(1);
`ifdef MEM_REQ_STATS_EN
        check_eq("stats_reqs3", 32'(bus_if.stat_reqs), 32'd3);
        check_eq("stats_hits2", 32'(bus_if.stat_hits), 32'd2);
        check_eq("stats_max12", 32'(bus_if.stat_maxlat), 32'd12);
`endif

        // Randomized traffic
        pv = 50; pd = 30;
        for (int i = 0; i < 2500; i++) begin
            if (i % 250 == 0) begin
                pv = $urandom_range(10, 90);
                pd = $urandom_range(3, 70);
            end
            r  = ($urandom_range(0, 299) != 0);
            v  = ($urandom_range(0, 99) < pv);
            dn = cur_v ? ($urandom_range(0, 99) < pd) : ($urandom_range(0, 99) < 5);
            cycle(r, v, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                  dn, 16'($urandom), 1'($urandom_range(0, 1)));
        end
        drain();
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
